mod_997_inv: RTL and testbench

MOD_997_INV -- requirements
Module: mod_997_inv

---
 rtl/mod_997_pkg.sv | 17 +
 rtl/mod_997_mulred.sv | 28 ++
 rtl/mod_997_inv.sv | 163 ++++++++++++++++
 tb/tb_mod_997_inv.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mod_997_pkg.sv
// Shared constants and types for the mod-997 Fermat inverter.
// The exponent is the Fermat exponent 995 (prime minus two).
package mod_997_pkg;

   localparam int unsigned MOD   = 997;
   localparam int unsigned W     = 10;
   localparam logic [W-1:0] EXP  = 10'b1111100011;
   localparam int unsigned STEPS = 9;

   typedef enum logic [1:0] {
      StIdle,
      StSqr,
      StMul,
      StDone
   } state_e;

endpackage

// File: rtl/mod_997_mulred.sv
// Combinational modular multiplier: p = (a * b) mod 997.
//
// Ports:
//   a, b  operands, each expected in 0..996
//   p     exact product mod 997, in 0..996
//
// Reduction uses 1024 = 27 (mod 997): fold the 20-bit product twice, then a
// single conditional subtract finishes it.
module mod_997_mulred
   import mod_997_pkg::*;
(
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] p
);

   logic [2*W-1:0] prod;
   logic [14:0]    fold1;   // <= 1023*27 + 1023 = 28644
   logic [10:0]    fold2;   // <= 27*27 + 1023 = 1752, so one subtract suffices

   always_comb begin
      prod  = (2*W)'(a) * (2*W)'(b);
      fold1 = 15'(prod[19:10]) * 15'd27 + 15'(prod[9:0]);
      fold2 = 11'(fold1[14:10]) * 11'd27 + 11'(fold1[9:0]);
      p     = W'((fold2 >= 11'(MOD)) ? (fold2 - 11'(MOD)) : fold2);
   end

endmodule

// File: rtl/mod_997_inv.sv
// Multiplicative inverse modulo 997 via Fermat: out_inv = in_a^995 mod 997.
//
// Left-to-right square-and-multiply over EXP: r = a at load, then for exponent
// bits 8..0 one SQR cycle and one MUL cycle (MUL result kept only when the bit
// is 1), so latency is constant: out_valid rises 18 edges after acceptance.
// A single shared mod_997_mulred serves both the square and the multiply.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready only in idle)
//   in_a                  10-bit unsigned operand
//   out_valid / out_ready result handshake; result held until consumed
//   out_inv               inverse of in_a mod 997
//   out_err               operand has no inverse or is out of range
//
// Configuration macro MOD997_INV_ERR_CHECK_EN:
//   defined   - in_a == 0 or in_a >= 997 skips the exponentiation; the result
//               (out_inv = 0, out_err = 1) is presented from the accepting edge.
//   undefined - out_err is always 0; in_a >= 997 is reduced by one subtraction
//               of 997 at load and a zero operand runs the normal path (result 0).
module mod_997_inv
   import mod_997_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_a,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_inv,
   output logic         out_err
);

   localparam logic [W-1:0] ModW = W'(MOD);

   state_e       state_q, state_d;
   logic [W-1:0] a_q, a_d;
   logic [W-1:0] r_q, r_d;
   logic [3:0]   bit_q, bit_d;
   logic         in_ready_q, in_ready_d;
   logic         out_valid_q, out_valid_d;
   logic [W-1:0] out_inv_q, out_inv_d;
   logic         out_err_q, out_err_d;

   logic [W-1:0] mul_b;
   logic [W-1:0] mul_p;
   logic [W-1:0] a_load;
   logic         a_bad;

   // Square uses r*r, multiply uses r*a.
   assign mul_b = (state_q == StSqr) ? r_q : a_q;

   mod_997_mulred u_mulred (
      .a (r_q),
      .b (mul_b),
      .p (mul_p)
   );

   always_comb begin
`ifdef MOD997_INV_ERR_CHECK_EN
      a_load = in_a;
      a_bad  = (in_a == '0) || (in_a >= ModW);
`else
      a_load = (in_a >= ModW) ? (in_a - ModW) : in_a;
      a_bad  = 1'b0;
`endif
   end

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      r_d         = r_q;
      bit_d       = bit_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      out_inv_d   = out_inv_q;
      out_err_d   = out_err_q;

      unique case (state_q)
         StIdle: begin
            if (in_valid && in_ready_q) begin
               a_d        = a_load;
               r_d        = a_load;
               bit_d      = 4'(STEPS - 1);
               in_ready_d = 1'b0;
               if (a_bad) begin
                  state_d     = StDone;
                  out_valid_d = 1'b1;
                  out_inv_d   = '0;
                  out_err_d   = 1'b1;
               end else begin
                  state_d = StSqr;
               end
            end
         end

         StSqr: begin
            r_d     = mul_p;
            state_d = StMul;
         end

         StMul: begin
            // The multiply always runs; its result is dropped for a 0 bit.
            if (EXP[bit_q]) begin
               r_d = mul_p;
            end
            if (bit_q == 4'd0) begin
               state_d     = StDone;
               out_valid_d = 1'b1;
               out_inv_d   = EXP[0] ? mul_p : r_q;
               out_err_d   = 1'b0;
            end else begin
               bit_d   = bit_q - 4'd1;
               state_d = StSqr;
            end
         end

         StDone: begin
            // in_ready returns only after this edge, so no same-cycle accept.
            if (out_ready) begin
               state_d     = StIdle;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
            end
         end

         default: begin
            state_d     = StIdle;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         a_q         <= '0;
         r_q         <= '0;
         bit_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_inv_q   <= '0;
         out_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         r_q         <= r_d;
         bit_q       <= bit_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_inv_q   <= out_inv_d;
         out_err_q   <= out_err_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_inv   = out_inv_q;
   assign out_err   = out_err_q;

endmodule

// File: tb/tb_mod_997_inv.sv
module tb_mod_997_inv;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [9:0] in_a;
   logic       out_valid;
   logic       out_ready;
   logic [9:0] out_inv;
   logic       out_err;

   typedef struct {
      int a;
      int inv;
      int err;
      int lat;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   mod_997_inv dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_inv   (out_inv),
      .out_err   (out_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int want);
      checks++;
      if (got != want) begin
         failures++;
         $display("FAIL %s got=%0d want=%0d", tag, got, want);
      end
   endtask

   // Extended Euclid inverse mod 997; returns 0 for 0.
   function automatic int inv_mod(input int a);
      int t, nt, r, nr, q, tmp;
      t = 0; nt = 1; r = 997; nr = a;
      while (nr != 0) begin
         q   = r / nr;
         tmp = t - q * nt; t = r; t = nt; nt = tmp;
         tmp = r - q * nr; r = nr; nr = tmp;
      end
      if (t < 0) t += 997;
      return t;
   endfunction

   function automatic exp_t model(input int a);
      exp_t e;
      e.a = a;
`ifdef MOD997_INV_ERR_CHECK_EN
      if (a == 0 || a >= 997) begin
         e.inv = 0; e.err = 1; e.lat = 0;
      end else begin
         e.inv = inv_mod(a); e.err = 0; e.lat = 18;
      end
`else
      e.inv = inv_mod((a >= 997) ? a - 997 : a);
      e.err = 0;
      e.lat = 18;
`endif
      return e;
   endfunction

   // One transaction: offer a, push expectation, wait for result, hold
   // out_ready low for 'hold' cycles, then consume.
   task automatic do_op(input int a, input exp_t e, input int hold);
      exp_t got_e;
      int   lat;
      bit   seen;
      @(negedge clk);
      out_ready = (hold == 0);
      check("in_ready_idle", int'(in_ready), 1);
      in_valid = 1'b1;
      in_a     = 10'(a);
      sb.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_a     = '0;
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat <= 40) begin
         if (out_valid) seen = 1'b1;
         else begin
            @(posedge clk);
            #1;
            lat++;
         end
      end
      got_e = sb.pop_front();
      if (!seen) begin
         check("timeout_out_valid", 0, 1);
         return;
      end
      check("latency", lat, got_e.lat);
      check("out_inv", int'(out_inv), got_e.inv);
      check("out_err", int'(out_err), got_e.err);
      if (hold > 0) begin
         for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", int'(out_valid), 1);
            check("hold_inv", int'(out_inv), got_e.inv);
            check("hold_in_ready", int'(in_ready), 0);
         end
         out_ready = 1'b1;
      end
      @(posedge clk);
      #1;
      check("consumed_valid", int'(out_valid), 0);
      check("consumed_in_ready", int'(in_ready), 1);
   endtask

   function automatic exp_t mk(input int a, input int inv);
      exp_t e;
      e.a = a; e.inv = inv; e.err = 0; e.lat = 18;
      return e;
   endfunction

   initial begin
      int fixed_a[4]   = '{2, 3, 1, 996};
      int fixed_inv[4] = '{499, 665, 1, 996};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_inv", int'(out_inv), 0);
      check("rst_out_err", int'(out_err), 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_in_ready", int'(in_ready), 1);

      // Hand-computed vectors.
      for (int i = 0; i < 4; i++) do_op(fixed_a[i], mk(fixed_a[i], fixed_inv[i]), 0);

      // Back-pressure: hold the result 5 cycles.
      do_op(7, model(7), 5);

      // Out-of-range / zero operands (behaviour depends on configuration).
      do_op(0, model(0), 0);
      do_op(1000, model(1000), 0);
      do_op(997, model(997), 0);

      // Exhaustive sweep.
      for (int a = 1; a <= 996; a++) do_op(a, model(a), 0);

      // Reset mid-operation: 7 cycles after acceptance.
      @(negedge clk);
      in_valid = 1'b1;
      in_a     = 10'd9;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (7) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", int'(out_valid), 0);
      check("midrst_in_ready", int'(in_ready), 1);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("midrst_rel_out_valid", int'(out_valid), 0);
      check("midrst_rel_in_ready", int'(in_ready), 1);
      repeat (25) begin
         @(posedge clk);
         #1;
         check("midrst_no_result", int'(out_valid), 0);
      end
      do_op(5, mk(5, 399), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
